vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Consumes the 40 MHz pixel clock from the PLL wrapper and produces 800x600@60 Hz VESA timing.
- Outputs: hsync, vsync, display-enable, pixel coordinates, and frame/line strobes for the downstream pixel/colour path.
- Free-running horizontal/vertical counters with registered outputs. Pixel-clock-enable input allows bench or divided-clock operation.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch (pixels); line total 1056
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines); frame total 628
- SYNC_POL, 1, active level of hsync/vsync (1 = positive, as VESA 800x600@60)

Ports:
- clk_in  input  1  40 MHz pixel clock (PLL clk_out)
- rst_n  input  1  synchronous active-low reset
- pix_ce  input  1  pixel clock enable; counters advance only when 1
- hsync  output  1  horizontal sync, polarity per SYNC_POL
- vsync  output  1  vertical sync, polarity per SYNC_POL
- de  output  1  display enable, 1 during the visible region
- pix_x  output  11  current pixel column (0..1055)
- pix_y  output  10  current line (0..627)
- line_start  output  1  one-cycle pulse at h=0
- frame_start  output  1  one-cycle pulse at h=0, v=0

Behaviour:
- Reset is synchronous and active-low. While rst_n=0 at a clk_in edge:
  - h_cnt=0, v_cnt=0
  - hsync=vsync=~SYNC_POL; de=0; pix_x=0; pix_y=0; line_start=0; frame_start=0
- Counters, on a clk_in edge with pix_ce=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only on the h_cnt wrap; at V_TOTAL-1 (with h wrap) it wraps to 0.
- pix_ce=0: counters and all outputs hold; strobes are forced to 0.
- Counter widths are sized by $clog2(total). Totals are computed as localparams (sum of four components).
- Outputs are registered from the current counter values, giving 1 cycle latency (counter value (h,v) appears on outputs one enabled edge later).
  - pix_x=h_cnt; pix_y=v_cnt
  - de = (h < H_VISIBLE) && (v < V_VISIBLE)
  - hsync active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (840..967 at defaults)
  - vsync active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (601..604), for the whole line, irrespective of h
  - line_start = (h==0); frame_start = (h==0 && v==0)
- First enabled edge after reset release: outputs show h=0,v=0, i.e. de=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: next edge returns to the reset state above; no partial sync pulse is held.
- Simultaneous h and v wrap: both counters go to 0 on the same edge.
- Any parameter set whose components are each >=1 must work. No runtime reconfiguration.

Optional Feature:
- Macro: VGA_SYNC_TEST_PATTERN_EN
- With the macro defined:
  - Extra output ports rgb_r, rgb_g, rgb_b, each 4 bits, registered and aligned with de (same latency).
  - 8 vertical colour bars, each H_VISIBLE/8 wide (100 px at defaults). Bar index b in 0..7 maps to r=b[2]?F:0, g=b[1]?F:0, b=b[0]?F:0.
  - All colours are 0 when de=0 and at reset.
- Without the macro: the rgb ports are absent and there is no pattern logic.

Decomposition:
- Shared package vga_pkg holds the default timing constants for 800x600@60 (H_*/V_* values, totals, coordinate widths), so the pixel path and the bench use identical numbers.
- One natural sub-module: vga_axis_counter, instantiated twice (horizontal and vertical). It takes parameters VISIBLE/FRONT/SYNC/BACK and SYNC_POL; inputs are a count enable and a wrap-enable; outputs are count, sync, active and wrap.

Test Plan:
- Reset held for 5 cycles, then released with pix_ce=1 -> first edge: pix_x=0, pix_y=0, de=1, frame_start=1; hsync=vsync=0 during reset (SYNC_POL=1).
- Run one line -> de high for exactly 800 cycles; hsync high for 128 cycles starting at pix_x=840; line_start period 1056 cycles.
- Run a full frame -> frame_start period 663168 cycles; vsync high exactly for lines 601..604 (4*1056 = 4224 cycles); de never high for pix_y>=600.
- Toggle pix_ce at 50% (alternating) -> outputs hold on disabled cycles; line period becomes 2112 clk_in cycles; strobes never high on a pix_ce=0 edge.
- Assert rst_n=0 at pix_x=900, pix_y=602 (inside both syncs) -> next edge hsync=vsync=0, de=0, counters 0; after release, timing restarts from the frame start.
- With VGA_SYNC_TEST_PATTERN_EN: pix_x=0 -> rgb=000; pix_x=100 -> (0,0,F); pix_x=799 -> (F,F,F); pix_x=800 -> 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default 800x600@60 timing constants, coordinate widths and colour-bar helper
package vga_pkg;
  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT = 40;
  localparam int DEF_H_SYNC = 128;
  localparam int DEF_H_BACK = 88;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT = 1;
  localparam int DEF_V_SYNC = 4;
  localparam int DEF_V_BACK = 23;
  localparam bit DEF_SYNC_POL = 1'b1;
  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_HW = $clog2(DEF_H_TOTAL);
  localparam int DEF_VW = $clog2(DEF_V_TOTAL);
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  function automatic rgb_t bar_rgb(input logic [2:0] idx);
    return '{r: {4{idx[2]}}, g: {4{idx[1]}}, b: {4{idx[0]}}};
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (position, sync, active, terminal count)
module vga_axis_counter #(
  parameter int VISIBLE = 800,
  parameter int FRONT = 40,
  parameter int SYNC = 128,
  parameter int BACK = 88,
  parameter bit SYNC_POL = 1'b1,
  parameter int W = $clog2(VISIBLE + FRONT + SYNC + BACK)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         wrap_en,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         active,
  output logic         wrap
);
  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_BEG = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] SYNC_END = W'(VISIBLE + FRONT + SYNC);
  // step on enable; wrap_en sends the count back to zero instead of incrementing
  always_ff @(posedge clk)
    if (!rst_n) count <= '0;
    else if (ce) count <= wrap_en ? '0 : count + 1'b1;
  // decode the current position within the axis
  always_comb begin
    wrap = count == LAST;
    active = count < VIS_END;
    sync = (count >= SYNC_BEG && count < SYNC_END) ? SYNC_POL : ~SYNC_POL;
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VESA sync/timing generator (800x600@60 default); VGA_SYNC_TEST_PATTERN_EN adds colour-bar rgb outputs
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter bit SYNC_POL = DEF_SYNC_POL,
  parameter int HW = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
  parameter int VW = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] pix_x,
  output logic [VW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_SYNC_TEST_PATTERN_EN
  ,
  output logic [3:0]    rgb_r,
  output logic [3:0]    rgb_g,
  output logic [3:0]    rgb_b
`endif
);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic h_sync, h_act, h_wrap;
  logic v_sync, v_act, v_wrap;
  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_POL(SYNC_POL), .W(HW)
  ) u_h (
    .clk(clk_in), .rst_n(rst_n), .ce(pix_ce), .wrap_en(h_wrap),
    .count(h_cnt), .sync(h_sync), .active(h_act), .wrap(h_wrap)
  );
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_POL(SYNC_POL), .W(VW)
  ) u_v (
    .clk(clk_in), .rst_n(rst_n), .ce(pix_ce && h_wrap), .wrap_en(v_wrap),
    .count(v_cnt), .sync(v_sync), .active(v_act), .wrap(v_wrap)
  );
  // register timing outputs one enabled edge behind the counters; strobes drop on idle edges
  always_ff @(posedge clk_in)
    if (!rst_n) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      de <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hsync <= h_sync;
      vsync <= v_sync;
      de <= h_act && v_act;
      pix_x <= h_cnt;
      pix_y <= v_cnt;
      line_start <= h_cnt == '0;
      frame_start <= h_cnt == '0 && v_cnt == '0;
    end else begin
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end
`ifdef VGA_SYNC_TEST_PATTERN_EN
  localparam int BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
  int unsigned bar_q;
  logic [2:0] bar;
  rgb_t bar_c;
  // pick the bar under the current column, clamping any remainder pixels into the last bar
  always_comb begin
    bar_q = 32'(h_cnt) / BAR_W;
    bar = (bar_q > 7) ? 3'd7 : bar_q[2:0];
    bar_c = bar_rgb(bar);
  end
  // colour registered alongside de so pixels line up with the timing outputs
  always_ff @(posedge clk_in)
    if (!rst_n) {rgb_r, rgb_g, rgb_b} <= '0;
    else if (pix_ce) {rgb_r, rgb_g, rgb_b} <= (h_act && v_act) ? bar_c : 12'h000;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default 800x600 instance for line/enable checks, small instance for frame/reset vectors
module tb_vga_sync_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic d_rst_n, d_ce, d_hs, d_vs, d_de, d_ls, d_fs;
  logic [10:0] d_x;
  logic [9:0] d_y;
  logic s_rst_n, s_ce, s_hs, s_vs, s_de, s_ls, s_fs;
  logic [3:0] s_x, s_y;
`ifdef VGA_SYNC_TEST_PATTERN_EN
  logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;
`endif

  vga_sync_gen d (
    .clk_in(clk), .rst_n(d_rst_n), .pix_ce(d_ce), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .pix_x(d_x), .pix_y(d_y), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_SYNC_TEST_PATTERN_EN
    , .rgb_r(d_r), .rgb_g(d_g), .rgb_b(d_b)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) s (
    .clk_in(clk), .rst_n(s_rst_n), .pix_ce(s_ce), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .pix_x(s_x), .pix_y(s_y), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_SYNC_TEST_PATTERN_EN
    , .rgb_r(s_r), .rgb_g(s_g), .rgb_b(s_b)
`endif
  );

  typedef struct {
    bit rst_n;
    bit ce;
    int n;
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } vec_t;
  vec_t tbl[19];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef VGA_SYNC_TEST_PATTERN_EN
  task automatic seek(input int tx, input int rgb);
    int n = 0;
    while (int'(d_x) != tx && n < 2200) begin
      tick();
      n++;
    end
    chk($sformatf("seek_x%0d", tx), int'(d_x), tx);
    chk($sformatf("rgb_x%0d", tx), int'({d_r, d_g, d_b}), rgb);
  endtask
`endif

  int de_n, hs_n, hs_first, hs_last, ls_n, fs_n, vs_n, seq_err;
  int hold_err, strobe_err, adv_err, ls1, ls2;
  logic [10:0] px;
  logic [9:0] py;
  logic pde, phs, pvs;

  initial begin
    // frame-level vectors for the 16x11 instance: {rst_n, ce, edges, x, y, de, hs, vs, ls, fs}
    tbl[0]  = '{1, 1, 1,   0,  0, 1, 0, 0, 1, 1};
    tbl[1]  = '{1, 0, 1,   0,  0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1,   1,  0, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 1,   1,  0, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 6,   7,  0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1,   8,  0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 2,  10,  0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 1, 2,  12,  0, 0, 1, 0, 0, 0};
    tbl[8]  = '{1, 1, 1,  13,  0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 2,  15,  0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 1, 1,   0,  1, 1, 0, 0, 1, 0};
    tbl[11] = '{1, 1, 80,  0,  6, 0, 0, 0, 1, 0};
    tbl[12] = '{1, 1, 16,  0,  7, 0, 0, 1, 1, 0};
    tbl[13] = '{1, 1, 27, 11,  8, 0, 1, 1, 0, 0};
    tbl[14] = '{0, 1, 1,   0,  0, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 1,   0,  0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 1,   0,  0, 1, 0, 0, 1, 1};
    tbl[17] = '{1, 1, 175, 15, 10, 0, 0, 0, 0, 0};
    tbl[18] = '{1, 1, 1,   0,  0, 1, 0, 0, 1, 1};

    d_rst_n = 1'b0;
    d_ce = 1'b1;
    s_rst_n = 1'b0;
    s_ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_hsync", d_hs, 0);
      chk("rst_vsync", d_vs, 0);
      chk("rst_de", d_de, 0);
      chk("rst_x", int'(d_x), 0);
      chk("rst_y", int'(d_y), 0);
      chk("rst_ls", d_ls, 0);
      chk("rst_fs", d_fs, 0);
`ifdef VGA_SYNC_TEST_PATTERN_EN
      chk("rst_rgb", int'({d_r, d_g, d_b}), 0);
`endif
    end
    chk("s_rst_x", int'(s_x), 0);
    chk("s_rst_hsync", s_hs, 0);

    d_rst_n = 1'b1;
    tick();
    chk("first_x", int'(d_x), 0);
    chk("first_y", int'(d_y), 0);
    chk("first_de", d_de, 1);
    chk("first_fs", d_fs, 1);
    chk("first_ls", d_ls, 1);
    chk("first_hsync", d_hs, 0);

    de_n = 0; hs_n = 0; hs_first = -1; hs_last = -1; ls_n = 0; fs_n = 0; vs_n = 0; seq_err = 0;
    for (int i = 0; i < 1056; i++) begin
      if (i > 0) tick();
      if (int'(d_x) != i || d_y != 10'd0) seq_err++;
      de_n += int'(d_de);
      ls_n += int'(d_ls);
      fs_n += int'(d_fs);
      vs_n += int'(d_vs);
      if (d_hs) begin
        if (hs_first < 0) hs_first = i;
        hs_last = i;
        hs_n++;
      end
    end
    chk("line_seq_err", seq_err, 0);
    chk("line_de_cycles", de_n, 800);
    chk("line_hs_cycles", hs_n, 128);
    chk("line_hs_first_x", hs_first, 840);
    chk("line_hs_last_x", hs_last, 967);
    chk("line_ls_count", ls_n, 1);
    chk("line_fs_count", fs_n, 1);
    chk("line_vs_cycles", vs_n, 0);
    tick();
    chk("line1_ls", d_ls, 1);
    chk("line1_x", int'(d_x), 0);
    chk("line1_y", int'(d_y), 1);
    chk("line1_fs", d_fs, 0);
    chk("line1_de", d_de, 1);

    px = d_x; py = d_y; pde = d_de; phs = d_hs; pvs = d_vs;
    ls1 = -1; ls2 = -1; hold_err = 0; strobe_err = 0; adv_err = 0;
    for (int k = 0; k < 6336; k++) begin
      d_ce = (k % 2) == 1;
      tick();
      if (!d_ce) begin
        if (d_x != px || d_y != py || d_de != pde || d_hs != phs || d_vs != pvs) hold_err++;
        if (d_ls || d_fs) strobe_err++;
      end else if (int'(d_x) != (int'(px) + 1) % 1056) adv_err++;
      if (d_ls) begin
        if (ls1 < 0) ls1 = k;
        else if (ls2 < 0) ls2 = k;
      end
      px = d_x; py = d_y; pde = d_de; phs = d_hs; pvs = d_vs;
    end
    d_ce = 1'b1;
    chk("alt_hold_err", hold_err, 0);
    chk("alt_strobe_err", strobe_err, 0);
    chk("alt_adv_err", adv_err, 0);
    chk("alt_line_period", (ls1 >= 0 && ls2 >= 0) ? ls2 - ls1 : -1, 2112);

`ifdef VGA_SYNC_TEST_PATTERN_EN
    seek(100, 12'h00F);
    seek(799, 12'hFFF);
    seek(800, 12'h000);
    seek(0, 12'h000);
    seek(250, 12'h0F0);
`endif

    for (int e = 0; e < 19; e++) begin
      s_rst_n = tbl[e].rst_n;
      s_ce = tbl[e].ce;
      for (int j = 0; j < tbl[e].n; j++) tick();
      chk($sformatf("v%0d_x", e), int'(s_x), tbl[e].x);
      chk($sformatf("v%0d_y", e), int'(s_y), tbl[e].y);
      chk($sformatf("v%0d_de", e), s_de, tbl[e].de);
      chk($sformatf("v%0d_hsync", e), s_hs, tbl[e].hs);
      chk($sformatf("v%0d_vsync", e), s_vs, tbl[e].vs);
      chk($sformatf("v%0d_ls", e), s_ls, tbl[e].ls);
      chk($sformatf("v%0d_fs", e), s_fs, tbl[e].fs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
